issue_queue: RTL

Out-of-order issue queue sitting directly downstream of the rename/register-file stage. Accepts one renamed instruction per cycle, tracks source-operand readiness by snooping the ALU and load write-back buses, and issues the oldest ready entry per cycle to execute through a registered valid/ready output stage. Drives `issue_hazard` back to rename when it cannot accept an instruction.

---
 rtl/issue_queue.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/issue_queue.sv
// Out-of-order issue queue: unordered entry storage with write-back wakeup and
// oldest-first select into a registered valid/ready output stage.
module issue_queue #(
  parameter int DEPTH    = 16,
  parameter int PREG_W   = 6,
  parameter int PREG_NUM = 64,
  parameter int AL_W     = 5,
  parameter int ADDR_W   = 32,
  localparam int CNT_W   = $clog2(DEPTH) + 1,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [ADDR_W-1:0]   in_pc,
  input  logic [PREG_W-1:0]   in_phys_rs,
  input  logic [PREG_W-1:0]   in_phys_rt,
  input  logic [PREG_W-1:0]   in_phys_rw,
  input  logic                in_is_load,
  input  logic                in_is_store,
  input  logic [AL_W-1:0]     in_al_id,
  input  logic                in_color,
  input  logic [PREG_NUM-1:0] preg_valid,
  input  logic                alu_wb_valid,
  input  logic [PREG_W-1:0]   alu_wb_tag,
  input  logic                ld_wb_valid,
  input  logic [PREG_W-1:0]   ld_wb_tag,
  input  logic                flush,
  output logic                issue_hazard,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_pc,
  output logic [PREG_W-1:0]   out_phys_rs,
  output logic [PREG_W-1:0]   out_phys_rt,
  output logic [PREG_W-1:0]   out_phys_rw,
  output logic                out_is_load,
  output logic                out_is_store,
  output logic [AL_W-1:0]     out_al_id,
  output logic                out_color,
  output logic [CNT_W-1:0]    count
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [PREG_W-1:0] rs;
    logic [PREG_W-1:0] rt;
    logic [PREG_W-1:0] rw;
    logic              is_load;
    logic              is_store;
    logic [AL_W-1:0]   al_id;
    logic              color;
  } payload_t;

  payload_t         ent [DEPTH];
  logic [DEPTH-1:0] busy, rs_rdy, rt_rdy;
  logic [DEPTH-1:0] rs_hit, rt_hit, eligible;
  logic [CNT_W-1:0] count_q;
  payload_t         out_q;
  logic             out_valid_q;

  payload_t         in_pl;
  logic             in_rs_rdy, in_rt_rdy;
  logic             insert, load_out, do_sel, sel_found;
  logic [IDX_W-1:0] free_idx, sel_idx;

  // Colour flips on every active-list wrap, so a differing colour inverts the id order.
  function automatic logic is_older(input logic ca, input logic [AL_W-1:0] aa,
                                    input logic cb, input logic [AL_W-1:0] ab);
    return (ca == cb) ? (aa < ab) : (aa > ab);
  endfunction

  assign issue_hazard = (count_q == CNT_W'(DEPTH));
  assign insert       = in_valid && !issue_hazard && !flush;
  assign load_out     = !out_valid_q || out_ready;
  assign do_sel       = load_out && sel_found;

  assign in_pl = '{pc: in_pc, rs: in_phys_rs, rt: in_phys_rt, rw: in_phys_rw,
                   is_load: in_is_load, is_store: in_is_store,
                   al_id: in_al_id, color: in_color};

  assign in_rs_rdy = preg_valid[in_phys_rs] || (alu_wb_valid && alu_wb_tag == in_phys_rs)
                                            || (ld_wb_valid  && ld_wb_tag  == in_phys_rs);
  assign in_rt_rdy = preg_valid[in_phys_rt] || (alu_wb_valid && alu_wb_tag == in_phys_rt)
                                            || (ld_wb_valid  && ld_wb_tag  == in_phys_rt);

  // NOTE: every variable gets a default before the loops so no latch is inferred.
  always_comb begin
    rs_hit    = '0;
    rt_hit    = '0;
    eligible  = '0;
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rs_hit[i]   = (alu_wb_valid && alu_wb_tag == ent[i].rs) || (ld_wb_valid && ld_wb_tag == ent[i].rs);
      rt_hit[i]   = (alu_wb_valid && alu_wb_tag == ent[i].rt) || (ld_wb_valid && ld_wb_tag == ent[i].rt);
      eligible[i] = busy[i] && rs_rdy[i] && rt_rdy[i];
    end
    // Scan downward so the lowest free index wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && (!sel_found ||
          is_older(ent[i].color, ent[i].al_id, ent[sel_idx].color, ent[sel_idx].al_id))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // NOTE: entry storage and ready bits are not reset; busy alone qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      rs_rdy[i] <= rs_rdy[i] | rs_hit[i];
      rt_rdy[i] <= rt_rdy[i] | rt_hit[i];
    end
    if (insert) begin
      ent[free_idx]    <= in_pl;
      rs_rdy[free_idx] <= in_rs_rdy;
      rt_rdy[free_idx] <= in_rt_rdy;
    end
  end

  // NOTE: non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      busy        <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (do_sel) busy[sel_idx] <= 1'b0;
      if (insert) busy[free_idx] <= 1'b1;
      count_q <= count_q + CNT_W'(insert) - CNT_W'(do_sel);
      if (load_out) begin
        out_valid_q <= sel_found;
        if (sel_found) out_q <= ent[sel_idx];
      end
    end
  end

  assign count        = count_q;
  assign out_valid    = out_valid_q;
  assign out_pc       = out_q.pc;
  assign out_phys_rs  = out_q.rs;
  assign out_phys_rt  = out_q.rt;
  assign out_phys_rw  = out_q.rw;
  assign out_is_load  = out_q.is_load;
  assign out_is_store = out_q.is_store;
  assign out_al_id    = out_q.al_id;
  assign out_color    = out_q.color;

endmodule
